// File: rtl/bank_scheduler.sv
// Round-robin scheduler between NCORE cores and NBANK single-port banks, one FSM per bank.
// Optional per-bank watchdog abort is enabled by defining SCHED_TIMEOUT_EN.
module bank_scheduler #(
  parameter int NCORE   = 16,
  parameter int NBANK   = 16,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255,
  localparam int BANK_W = $clog2(NBANK),
  localparam int CORE_W = $clog2(NCORE)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NCORE-1:0]                   core_val,
  input  logic [NCORE-1:0]                   read,
  input  logic [NCORE-1:0]                   write,
  input  logic [NCORE*(BANK_W+ADDR_W)-1:0]   addr_in,
  input  logic [NCORE*DATA_W-1:0]            data_in,
  output logic [NCORE*DATA_W-1:0]            data_out,
  output logic [NCORE-1:0]                   finish,
  output logic [NCORE-1:0]                   err,
  output logic [NBANK-1:0]                   bank_req,
  output logic [NBANK-1:0]                   bank_we,
  output logic [NBANK*ADDR_W-1:0]            bank_addr,
  output logic [NBANK*DATA_W-1:0]            bank_wdata,
  input  logic [NBANK-1:0]                   bank_done,
  input  logic [NBANK*DATA_W-1:0]            bank_rdata
);

  localparam int LANE_W = BANK_W + ADDR_W;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_q [NBANK];
  state_t            state_d [NBANK];
  logic [CORE_W-1:0] ptr_q   [NBANK];
  logic [CORE_W-1:0] ptr_d   [NBANK];
  logic [CORE_W-1:0] id_q    [NBANK];
  logic [CORE_W-1:0] win     [NBANK];
  logic [NCORE-1:0]  elig    [NBANK];
  logic [NBANK-1:0]  found, grant, complete, abort;
  logic [NCORE-1:0]  finish_d;

  // Any request other than a write is served as a read, so the read strobe carries no extra information.
  logic unused_read;
  assign unused_read = ^read;

  // A core whose finish bit is high is masked so a held core_val counts as a fresh request next cycle.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      elig[b] = '0;
      for (int c = 0; c < NCORE; c++) begin
        elig[b][c] = core_val[c] && !finish[c] &&
                     (addr_in[c*LANE_W+ADDR_W +: BANK_W] == BANK_W'(b));
      end
    end
  end

  always_comb begin : pick_p
    logic [CORE_W-1:0] idx;
    logic              hit;
    logic [CORE_W-1:0] sel;
    idx = '0;
    for (int b = 0; b < NBANK; b++) begin
      hit = 1'b0;
      sel = ptr_q[b];
      for (int k = 0; k < NCORE; k++) begin
        idx = ptr_q[b] + CORE_W'(k);
        if (!hit && elig[b][idx]) begin
          hit = 1'b1;
          sel = idx;
        end
      end
      found[b] = hit;
      win[b]   = sel;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [7:0]       cnt_q [NBANK];
  logic [NCORE-1:0] err_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_comb begin
    finish_d = '0;
`ifdef SCHED_TIMEOUT_EN
    err_d = '0;
`endif
    for (int b = 0; b < NBANK; b++) begin
      state_d[b]  = state_q[b];
      ptr_d[b]    = ptr_q[b];
      grant[b]    = 1'b0;
      complete[b] = 1'b0;
      abort[b]    = 1'b0;
      case (state_q[b])
        IDLE: begin
          if (found[b]) begin
            state_d[b] = BUSY;
            grant[b]   = 1'b1;
          end
        end
        BUSY: begin
          if (bank_done[b]) begin
            complete[b] = 1'b1;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (cnt_q[b] == 8'(TIMEOUT - 1)) begin
            abort[b] = 1'b1;
            err_d[id_q[b]] = 1'b1;
          end
`endif
          if (bank_done[b] || abort[b]) begin
            state_d[b]           = IDLE;
            ptr_d[b]             = id_q[b] + 1'b1;
            finish_d[id_q[b]]    = 1'b1;
          end
        end
        default: state_d[b] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NBANK; b++) begin
        state_q[b] <= IDLE;
        ptr_q[b]   <= '0;
        id_q[b]    <= '0;
      end
      bank_req   <= '0;
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      finish     <= '0;
      data_out   <= '0;
    end else begin
      finish <= finish_d;
      for (int b = 0; b < NBANK; b++) begin
        state_q[b] <= state_d[b];
        ptr_q[b]   <= ptr_d[b];
        if (grant[b]) begin
          bank_req[b]                      <= 1'b1;
          bank_we[b]                       <= write[win[b]];
          bank_addr[b*ADDR_W +: ADDR_W]    <= addr_in[win[b]*LANE_W +: ADDR_W];
          bank_wdata[b*DATA_W +: DATA_W]   <= data_in[win[b]*DATA_W +: DATA_W];
          id_q[b]                          <= win[b];
        end else if (complete[b] || abort[b]) begin
          bank_req[b] <= 1'b0;
        end
        if (complete[b] && !bank_we[b]) begin
          data_out[id_q[b]*DATA_W +: DATA_W] <= bank_rdata[b*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  // Watchdog counts BUSY edges since the grant; an abort still advances the pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NBANK; b++) cnt_q[b] <= '0;
      err <= '0;
    end else begin
      err <= err_d;
      for (int b = 0; b < NBANK; b++) begin
        if (grant[b]) cnt_q[b] <= '0;
        else if (state_q[b] == BUSY) cnt_q[b] <= cnt_q[b] + 8'd1;
      end
    end
  end
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_bank_scheduler.sv
// Directed bench for bank_scheduler: reactive bank model, completion scoreboard, round-robin and reset cases.
// Build with SCHED_TIMEOUT_EN defined to add the watchdog case.
module tb_bank_scheduler;
  localparam int NC = 16;
  localparam int NB = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [NC-1:0]    core_val = '0;
  logic [NC-1:0]    read = '0;
  logic [NC-1:0]    write = '0;
  logic [NC*12-1:0] addr_in = '0;
  logic [NC*8-1:0]  data_in = '0;
  logic [NC*8-1:0]  data_out;
  logic [NC-1:0]    finish;
  logic [NC-1:0]    err;
  logic [NB-1:0]    bank_req;
  logic [NB-1:0]    bank_we;
  logic [NB*8-1:0]  bank_addr;
  logic [NB*8-1:0]  bank_wdata;
  logic [NB-1:0]    bank_done = '0;
  logic [NB*8-1:0]  bank_rdata = '0;

  bank_scheduler dut (
    .clock(clock), .reset(reset), .core_val(core_val), .read(read), .write(write),
    .addr_in(addr_in), .data_in(data_in), .data_out(data_out), .finish(finish), .err(err),
    .bank_req(bank_req), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_done(bank_done), .bank_rdata(bank_rdata)
  );

  // Entry: [15:12] core, [11] read, [10] err expected, [7:0] read data.
  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cycle = 0;
  int issued[NC];
  int served[NC];
  int wcnt[NB];
  int lat[NB];
  logic [NB-1:0] req_seen = '0;
  logic [7:0]    mem[NB][256];
  logic [NC-1:0] last_fin = '0;
  int last_fin_cycle = 0;
  int err_cycle = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ent(input int c, input logic rd, input logic e, input logic [7:0] d);
    logic [3:0] cc;
    cc = c[3:0];
    return {cc, rd, e, 2'b00, d};
  endfunction

  task automatic issue(input int c, input int b, input logic [7:0] off, input logic wr,
                       input logic rd, input logic [7:0] d, input int n);
    logic [3:0] bb;
    bb = b[3:0];
    addr_in[c*12 +: 12] = {bb, off};
    write[c]            = wr;
    read[c]             = rd;
    data_in[c*8 +: 8]   = d;
    issued[c]          += n;
    core_val[c]         = 1'b1;
  endtask

  // One clock: bank model reacts after the rising edge, scoreboard and cores act on the falling edge.
  task automatic tick();
    logic [15:0] e;
    logic [7:0]  a;
    @(posedge clock);
    #1;
    for (int b = 0; b < NB; b++) begin
      a = bank_addr[b*8 +: 8];
      if (bank_done[b]) begin
        bank_done[b] = 1'b0;
        wcnt[b] = 0;
      end else if (req_seen[b] && a != 8'hEE) begin
        if (wcnt[b] + 1 >= lat[b]) begin
          if (bank_we[b]) mem[b][a] = bank_wdata[b*8 +: 8];
          else bank_rdata[b*8 +: 8] = mem[b][a];
          bank_done[b] = 1'b1;
          wcnt[b] = 0;
        end else begin
          wcnt[b]++;
        end
      end
    end
    @(negedge clock);
    cycle++;
    req_seen = bank_req;
    if (finish != '0) last_fin = finish;
    for (int c = 0; c < NC; c++) begin
      if (finish[c]) begin
        chk("bubble_req_low", bank_req[addr_in[c*12+8 +: 4]], 1'b0);
        if (exp_q.size() == 0) begin
          chk("sb_empty_on_finish", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("finish_core", c, e[15:12]);
          chk("err_flag", err[c], e[10]);
          if (e[11] && !e[10]) chk("rdata_lane", data_out[c*8 +: 8], e[7:0]);
        end
        if (err[c]) err_cycle = cycle;
        served[c]++;
        last_fin_cycle = cycle;
      end
    end
    chk("err_without_finish", err & ~finish, '0);
    for (int c = 0; c < NC; c++) core_val[c] = (issued[c] != served[c]);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || core_val != '0) && n < limit) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);
    tick();
    tick();
  endtask

  int t0;

  initial begin
    for (int c = 0; c < NC; c++) begin
      issued[c] = 0;
      served[c] = 0;
    end
    for (int b = 0; b < NB; b++) begin
      wcnt[b] = 0;
      lat[b]  = 1;
      for (int a = 0; a < 256; a++) mem[b][a] = 8'h00;
    end

    // Reset state
    tick();
    tick();
    chk("rst_finish", finish, '0);
    chk("rst_err", err, '0);
    chk("rst_bank_req", bank_req, '0);
    chk("rst_data_out", data_out, '0);
    reset = 1'b1;
    tick();
    chk("post_rst_bank_req", bank_req, '0);

    // Core 3 writes 0xA5 to bank 2 offset 0x10
    t0 = cycle;
    issue(3, 2, 8'h10, 1'b1, 1'b0, 8'hA5, 1);
    exp_q.push_back(ent(3, 1'b0, 1'b0, 8'h00));
    tick();
    chk("wr_bank_req", bank_req, 16'h0004);
    chk("wr_bank_we", bank_we[2], 1'b1);
    chk("wr_bank_addr", bank_addr[2*8 +: 8], 8'h10);
    chk("wr_bank_wdata", bank_wdata[2*8 +: 8], 8'hA5);
    wait_idle(50);
    chk("wr_finish_vec", last_fin, 16'h0008);
    chk("wr_latency", last_fin_cycle - t0, 3);
    chk("wr_mem", mem[2][8'h10], 8'hA5);

    // Core 3 reads it back
    issue(3, 2, 8'h10, 1'b0, 1'b1, 8'h00, 1);
    exp_q.push_back(ent(3, 1'b1, 1'b0, 8'hA5));
    wait_idle(50);
    chk("rd_lane3", data_out[31:24], 8'hA5);

    // Cores 0, 5, 15 contend on bank 7; core 0 asks twice
    mem[7][8'h01] = 8'h30;
    mem[7][8'h05] = 8'h35;
    mem[7][8'h0F] = 8'h3F;
    issue(0, 7, 8'h01, 1'b0, 1'b1, 8'h00, 2);
    issue(5, 7, 8'h05, 1'b0, 1'b1, 8'h00, 1);
    issue(15, 7, 8'h0F, 1'b0, 1'b1, 8'h00, 1);
    exp_q.push_back(ent(0, 1'b1, 1'b0, 8'h30));
    exp_q.push_back(ent(5, 1'b1, 1'b0, 8'h35));
    exp_q.push_back(ent(15, 1'b1, 1'b0, 8'h3F));
    exp_q.push_back(ent(0, 1'b1, 1'b0, 8'h30));
    wait_idle(100);

    // Two banks in parallel, completing together
    mem[4][8'h44] = 8'h14;
    mem[9][8'h99] = 8'h29;
    issue(1, 4, 8'h44, 1'b0, 1'b1, 8'h00, 1);
    issue(2, 9, 8'h99, 1'b0, 1'b1, 8'h00, 1);
    exp_q.push_back(ent(1, 1'b1, 1'b0, 8'h14));
    exp_q.push_back(ent(2, 1'b1, 1'b0, 8'h29));
    tick();
    chk("par_bank_req", bank_req, 16'h0210);
    wait_idle(50);
    chk("par_finish_vec", last_fin, 16'h0006);

    // Write wins over read; then no strobe at all is served as a read (slow bank)
    lat[3] = 3;
    issue(4, 3, 8'h22, 1'b1, 1'b1, 8'h5C, 1);
    exp_q.push_back(ent(4, 1'b0, 1'b0, 8'h00));
    tick();
    chk("ww_bank_we", bank_we[3], 1'b1);
    wait_idle(50);
    issue(4, 3, 8'h22, 1'b0, 1'b0, 8'h00, 1);
    exp_q.push_back(ent(4, 1'b1, 1'b0, 8'h5C));
    wait_idle(50);

    // Stray bank_done on an idle bank
    bank_done[11] = 1'b1;
    tick();
    tick();
    chk("idle_done_finish", finish, '0);
    chk("idle_done_req", bank_req, '0);

    // Reset in the middle of a transaction on a silent bank
    issue(6, 5, 8'hEE, 1'b0, 1'b1, 8'h00, 1);
    tick();
    tick();
    tick();
    chk("mid_req_held", bank_req[5], 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", bank_req, '0);
    chk("mid_rst_finish", finish, '0);
    chk("mid_rst_data_out", data_out, '0);
    served[6] = issued[6];
    core_val = '0;
    bank_done = '0;
    req_seen = '0;
    for (int b = 0; b < NB; b++) wcnt[b] = 0;
    tick();
    reset = 1'b1;
    tick();

    // Pointers return to core 0 after reset: 0 beats 5 on bank 7
    issue(5, 7, 8'h05, 1'b0, 1'b1, 8'h00, 1);
    issue(0, 7, 8'h01, 1'b0, 1'b1, 8'h00, 1);
    exp_q.push_back(ent(0, 1'b1, 1'b0, 8'h30));
    exp_q.push_back(ent(5, 1'b1, 1'b0, 8'h35));
    wait_idle(100);

`ifdef SCHED_TIMEOUT_EN
    // Bank 6 never answers core 8; core 9 is served after the abort
    mem[6][8'h01] = 8'h66;
    issue(8, 6, 8'hEE, 1'b0, 1'b1, 8'h00, 1);
    issue(9, 6, 8'h01, 1'b0, 1'b1, 8'h00, 1);
    exp_q.push_back(ent(8, 1'b1, 1'b1, 8'h00));
    exp_q.push_back(ent(9, 1'b1, 1'b0, 8'h66));
    tick();
    t0 = cycle;
    chk("to_bank_req", bank_req[6], 1'b1);
    wait_idle(700);
    chk("to_abort_cycles", err_cycle - t0, 255);
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
